// File: rtl/line_mem_pkg.sv
// Shared types and derived sizes for the line-refill/write-back memory responder.
package line_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, BEAT, RESP} state_t;

  localparam int BEATS_PER_LINE = 128 / 32;
  localparam int OFFSET_BITS    = $clog2(128 / 8);
  localparam int BEAT_BITS      = $clog2(BEATS_PER_LINE);

  // Counter/address widths never collapse to zero bits.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/line_mem_responder_word_ram.sv
// Word-wide backing store: asynchronous read, synchronous write, no reset.
module word_ram #(
  parameter int WORD_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int AW         = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [WORD_WIDTH-1:0] wd,
  output logic [WORD_WIDTH-1:0] rd
);

  logic [WORD_WIDTH-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wd;
  end

  assign rd = mem[addr];

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder: one line request at a time, LATENCY wait cycles,
// one word beat per cycle against word_ram, then a single-cycle response pulse.
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int LINE_WIDTH    = 128,
  parameter int WORD_WIDTH    = 32,
  parameter int MEM_WORDS     = 1024,
  parameter int LATENCY       = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic                     resp_we,
  output logic [LINE_WIDTH-1:0]    resp_rdata
);

  localparam int NBEATS   = LINE_WIDTH / WORD_WIDTH;
  localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);
  localparam int BB       = clog2_min1(NBEATS);
  localparam int MEM_AW   = clog2_min1(MEM_WORDS);
  localparam int LINE_AW  = MEM_AW - BB;
  localparam int LAT_W    = clog2_min1(LATENCY + 1);

  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [BB-1:0]    BEAT_LAST = BB'(NBEATS - 1);

  state_t                               state_q;
  logic [LAT_W-1:0]                     lat_cnt;
  logic [BB-1:0]                        beat_cnt;
  logic [LINE_AW-1:0]                   line_q;
  logic                                 we_q;
  logic [NBEATS-1:0][WORD_WIDTH-1:0]    wdata_q;
  logic [NBEATS-1:0][WORD_WIDTH-1:0]    buf_q;
  logic [NBEATS-1:0][WORD_WIDTH-1:0]    buf_nxt;
  logic [WORD_WIDTH-1:0]                ram_rd;
  logic                                 ram_we;
  logic [MEM_AW-1:0]                    ram_addr;
  logic                                 unused_addr;

  // Address bits above the backing-store depth alias silently (wrap).
  assign unused_addr = &{1'b0, req_addr};

  assign req_ready = (state_q == IDLE);
  assign ram_we    = (state_q == BEAT) && we_q;
  assign ram_addr  = {line_q, beat_cnt};

  always_comb begin
    buf_nxt           = buf_q;
    buf_nxt[beat_cnt] = ram_rd;
  end

  word_ram #(
    .WORD_WIDTH (WORD_WIDTH),
    .MEM_WORDS  (MEM_WORDS),
    .AW         (MEM_AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wd   (wdata_q[beat_cnt]),
    .rd   (ram_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lat_cnt    <= '0;
      beat_cnt   <= '0;
      line_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      buf_q      <= '0;
      resp_valid <= 1'b0;
      resp_we    <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_we    <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          line_q   <= req_addr[OFF_BITS +: LINE_AW];
          we_q     <= req_we;
          wdata_q  <= req_wdata;
          lat_cnt  <= '0;
          beat_cnt <= '0;
          state_q  <= (LATENCY == 0) ? BEAT : WAIT;
        end
        WAIT: begin
          if (lat_cnt == LAT_LAST) state_q <= BEAT;
          else                     lat_cnt <= lat_cnt + 1'b1;
        end
        BEAT: begin
          if (!we_q) buf_q <= buf_nxt;
          if (beat_cnt == BEAT_LAST) begin
            state_q    <= RESP;
            resp_valid <= 1'b1;
            resp_we    <= we_q;
            // The last word is still on the async read port this cycle.
            if (!we_q) resp_rdata <= buf_nxt;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
